// File: rtl/store_unit.sv
// store_unit: memory-stage store path.
//
// Decodes a store against the address map, aligns data and byte enables for
// DMEM/IMEM, and forwards UART TX bytes through a one-entry buffer with a
// ready/valid handshake. Every memory/MMIO output is registered: a store
// accepted at edge N is visible during cycle N+1 only.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   st_valid/addr/data/funct3  store issued by the pipeline
//   stall                  combinational; UART buffer cannot take the store
//   dmem_we, imem_we       byte enables
//   mem_addr, mem_din      word address and lane-aligned data
//   uart_tx_data/valid/ready  one-entry TX buffer handshake
//   ctr_reset              pulse clearing cycle/instret counters
//   misaligned             pulse marking a dropped misaligned store
//
// Configuration macro: STORE_CTR_RST_EN enables the counter-reset register at
// 0x80000018; without it ctr_reset is tied to 0.
module store_unit #(
  parameter int unsigned MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [2:0]        st_funct3,
  output logic              stall,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  output logic              ctr_reset,
  output logic              misaligned
);

  localparam logic [31:0] UartTxAddr = 32'h8000_0008;
  localparam logic [31:0] CtrRstAddr = 32'h8000_0018;

  typedef enum logic {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic [3:0]        dmem_we_q, dmem_we_d;
  logic [3:0]        imem_we_q, imem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic [7:0]        uart_data_q, uart_data_d;
  logic              ctr_reset_q, ctr_reset_d;
  logic              misaligned_q, misaligned_d;

  // Address decode
  logic is_dmem, is_imem, is_uart, is_ctr;
  always_comb begin
    is_dmem = (st_addr[31:28] == 4'b0001) || (st_addr[31:28] == 4'b0011);
    is_imem = (st_addr[31:28] == 4'b0010) || (st_addr[31:28] == 4'b0011);
    is_uart = (st_addr == UartTxAddr);
    is_ctr  = (st_addr == CtrRstAddr);
  end

  // Alignment of byte enables and data lanes
  logic [1:0]  off;
  logic [3:0]  be;
  logic [31:0] din_al;
  logic        f3_ok, mis;
  always_comb begin
    off    = st_addr[1:0];
    be     = 4'b0000;
    din_al = 32'h0;
    f3_ok  = 1'b1;
    mis    = 1'b0;
    case (st_funct3)
      3'b000: begin
        be     = 4'b0001 << off;
        din_al = {4{st_data[7:0]}};
      end
      3'b001: begin
        be     = 4'b0011 << off;
        din_al = {2{st_data[15:0]}};
        mis    = off[0];
      end
      3'b010: begin
        be     = 4'b1111;
        din_al = st_data;
        mis    = (off != 2'b00);
      end
      default: f3_ok = 1'b0;
    endcase
  end

  logic hs, uart_acc;
  always_comb begin
    hs       = uart_tx_valid && uart_tx_ready;
    stall    = st_valid && is_uart && (state_q == StFull) && !hs;
    uart_acc = st_valid && is_uart && !stall;
  end

  always_comb begin
    dmem_we_d    = 4'b0000;
    imem_we_d    = 4'b0000;
    mem_addr_d   = '0;
    mem_din_d    = 32'h0;
    misaligned_d = 1'b0;
    ctr_reset_d  = 1'b0;
    uart_data_d  = uart_data_q;
    state_d      = state_q;

    if (st_valid && (is_dmem || is_imem) && f3_ok) begin
      if (mis) begin
        misaligned_d = 1'b1;
      end else begin
        dmem_we_d  = is_dmem ? be : 4'b0000;
        imem_we_d  = is_imem ? be : 4'b0000;
        mem_addr_d = st_addr[MEM_AW+1:2];
        mem_din_d  = din_al;
      end
    end

`ifdef STORE_CTR_RST_EN
    ctr_reset_d = st_valid && is_ctr;
`else
    ctr_reset_d = 1'b0 & is_ctr;
`endif

    // A new byte may replace a full buffer only in the handshake cycle,
    // which is exactly when uart_acc is allowed while full.
    unique case (state_q)
      StEmpty: begin
        if (uart_acc) begin
          uart_data_d = st_data[7:0];
          state_d     = StFull;
        end
      end
      StFull: begin
        if (uart_acc) begin
          uart_data_d = st_data[7:0];
        end else if (hs) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StEmpty;
      dmem_we_q    <= 4'b0000;
      imem_we_q    <= 4'b0000;
      mem_addr_q   <= '0;
      mem_din_q    <= 32'h0;
      uart_data_q  <= 8'h00;
      ctr_reset_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      dmem_we_q    <= dmem_we_d;
      imem_we_q    <= imem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      uart_data_q  <= uart_data_d;
      ctr_reset_q  <= ctr_reset_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign dmem_we       = dmem_we_q;
  assign imem_we       = imem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_din       = mem_din_q;
  assign uart_tx_data  = uart_data_q;
  assign uart_tx_valid = (state_q == StFull);
  assign ctr_reset     = ctr_reset_q;
  assign misaligned    = misaligned_q;

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: each step drives one cycle of stimulus, pushes
// the expected registered outputs to a scoreboard queue, and pops/compares
// them once the DUT has clocked.
module tb_store_unit;

`ifdef STORE_CTR_RST_EN
  localparam bit CtrEn = 1'b1;
`else
  localparam bit CtrEn = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        stall;
  logic [3:0]  dmem_we;
  logic [3:0]  imem_we;
  logic [13:0] mem_addr;
  logic [31:0] mem_din;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic        ctr_reset;
  logic        misaligned;

  store_unit #(.MEM_AW(14)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .st_funct3    (st_funct3),
    .stall        (stall),
    .dmem_we      (dmem_we),
    .imem_we      (imem_we),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .ctr_reset    (ctr_reset),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  dwe;
    logic [3:0]  iwe;
    logic [13:0] addr;
    logic [31:0] din;
    logic        mis;
    logic        ctr;
    logic        tv;
    logic [7:0]  td;
    logic        chk_td;
  } exp_t;

  exp_t scb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] dwe, input logic [3:0] iwe,
                              input logic [13:0] addr, input logic [31:0] din,
                              input logic mis, input logic ctr, input logic tv,
                              input logic [7:0] td);
    exp_t e;
    e.dwe = dwe; e.iwe = iwe; e.addr = addr; e.din = din;
    e.mis = mis; e.ctr = ctr; e.tv = tv; e.td = td; e.chk_td = tv;
    return e;
  endfunction

  // Quiet outputs with the UART buffer in the given state.
  function automatic exp_t idle(input logic tv, input logic [7:0] td);
    return mk(4'h0, 4'h0, 14'h0, 32'h0, 1'b0, 1'b0, tv, td);
  endfunction

  task automatic step(input logic rst, input logic v, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] f3, input logic rdy,
                      input logic exp_stall, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst_n         = ~rst;
    st_valid      = v;
    st_addr       = a;
    st_data       = d;
    st_funct3     = f3;
    uart_tx_ready = rdy;
    #1;
    check_eq("stall", {31'h0, stall}, {31'h0, exp_stall});
    scb_q.push_back(e);
    @(posedge clk);
    #1;
    got = scb_q.pop_front();
    check_eq("dmem_we", {28'h0, dmem_we}, {28'h0, got.dwe});
    check_eq("imem_we", {28'h0, imem_we}, {28'h0, got.iwe});
    check_eq("mem_addr", {18'h0, mem_addr}, {18'h0, got.addr});
    check_eq("mem_din", mem_din, got.din);
    check_eq("misaligned", {31'h0, misaligned}, {31'h0, got.mis});
    check_eq("ctr_reset", {31'h0, ctr_reset}, {31'h0, got.ctr});
    check_eq("uart_tx_valid", {31'h0, uart_tx_valid}, {31'h0, got.tv});
    if (got.chk_td) check_eq("uart_tx_data", {24'h0, uart_tx_data}, {24'h0, got.td});
  endtask

  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    st_funct3 = '0; uart_tx_ready = 1'b0;

    // Reset state
    step(1, 0, 32'h0, 32'h0, SB, 0, 0, idle(0, 8'h00));
    step(1, 0, 32'h0, 32'h0, SB, 0, 0, idle(0, 8'h00));

    // Memory stores
    step(0, 1, 32'h1000_0006, 32'h0000_00AB, SB, 0, 0,
         mk(4'b0100, 4'b0000, 14'd1, 32'hABAB_ABAB, 0, 0, 0, 8'h00));
    step(0, 0, 32'h0, 32'h0, SB, 0, 0, idle(0, 8'h00));
    step(0, 1, 32'h3000_0003, 32'h0000_1234, SH, 0, 0,
         mk(4'b0000, 4'b0000, 14'd0, 32'h0, 1, 0, 0, 8'h00));
    step(0, 1, 32'h3000_0010, 32'hDEAD_BEEF, SW, 0, 0,
         mk(4'b1111, 4'b1111, 14'd4, 32'hDEAD_BEEF, 0, 0, 0, 8'h00));
    step(0, 1, 32'h2000_0002, 32'h1234_5678, SH, 0, 0,
         mk(4'b0000, 4'b1100, 14'd0, 32'h5678_5678, 0, 0, 0, 8'h00));
    step(0, 1, 32'h1000_0001, 32'h0000_00C3, SB, 0, 0,
         mk(4'b0010, 4'b0000, 14'd0, 32'hC3C3_C3C3, 0, 0, 0, 8'h00));
    step(0, 1, 32'h1000_0102, 32'h0000_005A, SB, 0, 0,
         mk(4'b0100, 4'b0000, 14'd64, 32'h5A5A_5A5A, 0, 0, 0, 8'h00));
    step(0, 1, 32'h1000_0006, 32'hCAFE_F00D, SW, 0, 0,
         mk(4'b0000, 4'b0000, 14'd0, 32'h0, 1, 0, 0, 8'h00));
    // Invalid funct3, unmapped region, unmapped MMIO
    step(0, 1, 32'h1000_0000, 32'hFFFF_FFFF, 3'b011, 0, 0, idle(0, 8'h00));
    step(0, 1, 32'h4000_0000, 32'hFFFF_FFFF, SW, 0, 0, idle(0, 8'h00));
    step(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, SW, 0, 0, idle(0, 8'h00));

    // UART: second byte stalls until a handshake, then replaces without a gap
    step(0, 1, 32'h8000_0008, 32'h0000_0041, SB, 0, 0, idle(1, 8'h41));
    step(0, 1, 32'h8000_0008, 32'h0000_0042, SB, 0, 1, idle(1, 8'h41));
    step(0, 1, 32'h8000_0008, 32'h0000_0042, SB, 0, 1, idle(1, 8'h41));
    step(0, 1, 32'h8000_0008, 32'h0000_0042, SB, 1, 0, idle(1, 8'h42));
    step(0, 0, 32'h0, 32'h0, SB, 0, 0, idle(1, 8'h42));
    // Memory store while UART pending is unaffected
    step(0, 1, 32'h1000_0000, 32'h0000_0099, SB, 0, 0,
         mk(4'b0001, 4'b0000, 14'd0, 32'h9999_9999, 0, 0, 1, 8'h42));
    step(0, 0, 32'h0, 32'h0, SB, 1, 0, idle(0, 8'h00));
    // MMIO ignores funct3/alignment; UART uses bits [7:0]
    step(0, 1, 32'h8000_0008, 32'h0000_1177, SH, 0, 0, idle(1, 8'h77));

    // Reset discards the pending byte; reset wins over a memory store
    step(1, 1, 32'h1000_0000, 32'h1111_1111, SW, 0, 0, idle(0, 8'h00));
    step(0, 1, 32'h8000_0008, 32'h0000_0066, SB, 0, 0, idle(1, 8'h66));
    step(0, 0, 32'h0, 32'h0, SB, 1, 0, idle(0, 8'h00));

    // Counter reset pulse
    step(0, 1, 32'h8000_0018, 32'h0, SW, 0, 0,
         mk(4'h0, 4'h0, 14'h0, 32'h0, 0, CtrEn, 0, 8'h00));
    step(0, 0, 32'h0, 32'h0, SB, 0, 0, idle(0, 8'h00));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
